// File: rtl/shift_arbiter_pkg.sv
// Shared types and constants for the shift arbiter and its barrel shifter.
package shift_arbiter_pkg;

   localparam int unsigned N_REQ   = 2;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned SHAMT_W = 5;

   typedef logic req_idx_t;

   localparam logic [DATA_W-1:0] RESP_DATA_RST = '0;

endpackage

// File: rtl/shift_arbiter_left_shift.sv
// Five-layer 32-bit logical left barrel shifter; vacated bits are zero-filled.
module left_shift
   import shift_arbiter_pkg::*;
(
   input  logic [DATA_W-1:0]  data,
   input  logic [SHAMT_W-1:0] amt,
   output logic [DATA_W-1:0]  result
);

   logic [DATA_W-1:0] layer;

   // Layer i shifts by 2**i when amt[i] is set.
   always_comb begin
      layer = data;
      for (int unsigned i = 0; i < SHAMT_W; i++) begin
         if (amt[i])
            layer = layer << (1 << i);
      end
      result = layer;
   end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin sharing of one left barrel shifter between two valid/ready requesters,
// with a single registered result stage and a wrapping completed-transaction counter.
module shift_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [DATA_W-1:0] req_data0,
   input  logic [4:0]        req_amt0,
   input  logic [DATA_W-1:0] req_data1,
   input  logic [4:0]        req_amt1,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_id,
   output logic [CNT_W-1:0]  done_count
);

   import shift_arbiter_pkg::*;

   logic              slot_free;
   logic              gnt_valid;
   req_idx_t          gnt_id;
   req_idx_t          ptr;
   logic [DATA_W-1:0] sel_data;
   logic [4:0]        sel_amt;
   logic [DATA_W-1:0] shifted;

   assign slot_free = !resp_valid || resp_ready;

   always_comb begin
      gnt_valid = 1'b0;
      gnt_id    = 1'b0;
      if (slot_free) begin
         case (req_valid)
            2'b01: begin
               gnt_valid = 1'b1;
               gnt_id    = 1'b0;
            end
            2'b10: begin
               gnt_valid = 1'b1;
               gnt_id    = 1'b1;
            end
            2'b11: begin
               gnt_valid = 1'b1;
               gnt_id    = ptr;
            end
            default: begin
               gnt_valid = 1'b0;
               gnt_id    = 1'b0;
            end
         endcase
      end
   end

   // Gated by reset_n so no requester sees an accept while reset is asserted.
   always_comb begin
      req_ready = '0;
      if (gnt_valid && reset_n)
         req_ready[gnt_id] = 1'b1;
   end

   assign sel_data = gnt_id ? req_data1 : req_data0;
   assign sel_amt  = gnt_id ? req_amt1  : req_amt0;

   left_shift u_left_shift (
      .data   (sel_data),
      .amt    (sel_amt),
      .result (shifted)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         resp_valid <= 1'b0;
         resp_data  <= RESP_DATA_RST;
         resp_id    <= 1'b0;
         ptr        <= 1'b0;
         done_count <= '0;
      end else begin
         if (gnt_valid) begin
            resp_valid <= 1'b1;
            resp_data  <= shifted;
            resp_id    <= gnt_id;
            ptr        <= ~gnt_id;
         end else if (resp_ready) begin
            resp_valid <= 1'b0;
         end
         if (resp_valid && resp_ready)
            done_count <= done_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed vector bench for shift_arbiter: table of per-cycle vectors plus reset and wrap sequences.
module tb_shift_arbiter;

   logic        clock;
   logic        reset_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req_data0;
   logic [4:0]  req_amt0;
   logic [31:0] req_data1;
   logic [4:0]  req_amt1;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_id;
   logic [15:0] done_count;

   int unsigned n_checks;
   int unsigned n_fail;

   shift_arbiter #(
      .DATA_W (32),
      .CNT_W  (16)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_data0  (req_data0),
      .req_amt0   (req_amt0),
      .req_data1  (req_data1),
      .req_amt1   (req_amt1),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_id    (resp_id),
      .done_count (done_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic [1:0]  valid;
      logic [31:0] d0;
      logic [4:0]  a0;
      logic [31:0] d1;
      logic [4:0]  a1;
      logic        rr;
      logic [1:0]  exp_ready;
      logic        exp_rv;
      logic        chk_data;
      logic [31:0] exp_data;
      logic        exp_id;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [1:0] valid, input logic [31:0] d0, input logic [4:0] a0,
                      input logic [31:0] d1, input logic [4:0] a1, input logic rr,
                      input logic [1:0] exp_ready, input logic exp_rv, input logic chk_data,
                      input logic [31:0] exp_data, input logic exp_id, input logic [15:0] exp_cnt);
      vec_t v;
      v.valid = valid; v.d0 = d0; v.a0 = a0; v.d1 = d1; v.a1 = a1; v.rr = rr;
      v.exp_ready = exp_ready; v.exp_rv = exp_rv; v.chk_data = chk_data;
      v.exp_data = exp_data; v.exp_id = exp_id; v.exp_cnt = exp_cnt;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Requester protocol: an unaccepted request keeps valid and operands stable.
   logic [1:0]  pv, pr;
   logic [31:0] pd0, pd1;
   logic [4:0]  pa0, pa1;
   logic        prst;

   initial prst = 1'b0;

   always @(negedge clock) begin
      if (prst && reset_n) begin
         if (pv[0] && !pr[0])
            assert (req_valid[0] && req_data0 == pd0 && req_amt0 == pa0)
               else $error("requester 0 changed its request before acceptance");
         if (pv[1] && !pr[1])
            assert (req_valid[1] && req_data1 == pd1 && req_amt1 == pa1)
               else $error("requester 1 changed its request before acceptance");
      end
      pv   = req_valid;
      pr   = req_ready;
      pd0  = req_data0;
      pd1  = req_data1;
      pa0  = req_amt0;
      pa1  = req_amt1;
      prst = reset_n;
   end

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      reset_n    = 1'b0;
      req_valid  = 2'b11;
      req_data0  = '0;
      req_amt0   = '0;
      req_data1  = '0;
      req_amt1   = '0;
      resp_ready = 1'b1;

      // valid  d0            a0  d1            a1  rr  ready  rv  chk  data          id  cnt
      add(2'b01, 32'h0000_00F1, 4, 32'h0,        0, 1, 2'b01, 1, 1, 32'h0000_0F10, 0, 16'd0);
      add(2'b00, 32'h0000_00F1, 4, 32'h0,        0, 1, 2'b00, 0, 0, 32'h0,         0, 16'd1);
      add(2'b11, 32'h1,        31, 32'hFFFF_FFFF,16, 1, 2'b10, 1, 1, 32'hFFFF_0000, 1, 16'd1);
      add(2'b11, 32'h1,        31, 32'hFFFF_FFFF,16, 1, 2'b01, 1, 1, 32'h8000_0000, 0, 16'd2);
      add(2'b11, 32'h1,        31, 32'hFFFF_FFFF,16, 1, 2'b10, 1, 1, 32'hFFFF_0000, 1, 16'd3);
      add(2'b11, 32'h1,        31, 32'hFFFF_FFFF,16, 1, 2'b01, 1, 1, 32'h8000_0000, 0, 16'd4);
      add(2'b11, 32'hDEAD_BEEF, 0, 32'hFFFF_FFFF,16, 1, 2'b10, 1, 1, 32'hFFFF_0000, 1, 16'd5);
      add(2'b01, 32'hDEAD_BEEF, 0, 32'hFFFF_FFFF,16, 1, 2'b01, 1, 1, 32'hDEAD_BEEF, 0, 16'd6);
      add(2'b10, 32'hDEAD_BEEF, 0, 32'h0000_0003,31, 1, 2'b10, 1, 1, 32'h8000_0000, 1, 16'd7);
      add(2'b11, 32'h1234_5678, 8, 32'h1,         1, 0, 2'b00, 1, 1, 32'h8000_0000, 1, 16'd7);
      add(2'b11, 32'h1234_5678, 8, 32'h1,         1, 0, 2'b00, 1, 1, 32'h8000_0000, 1, 16'd7);
      add(2'b11, 32'h1234_5678, 8, 32'h1,         1, 0, 2'b00, 1, 1, 32'h8000_0000, 1, 16'd7);
      add(2'b11, 32'h1234_5678, 8, 32'h1,         1, 1, 2'b01, 1, 1, 32'h3456_7800, 0, 16'd8);
      add(2'b10, 32'h1234_5678, 8, 32'h1,         1, 1, 2'b10, 1, 1, 32'h0000_0002, 1, 16'd9);
      add(2'b00, 32'h1234_5678, 8, 32'h1,         1, 0, 2'b00, 1, 1, 32'h0000_0002, 1, 16'd9);
      add(2'b00, 32'h1234_5678, 8, 32'h1,         1, 1, 2'b00, 0, 0, 32'h0,         0, 16'd10);

      // Reset held with both requesters valid.
      repeat (2) @(posedge clock);
      #1;
      chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("reset_req_ready", {30'd0, req_ready}, 32'd0);
      chk("reset_done_count", {16'd0, done_count}, 32'd0);
      chk("reset_resp_data", resp_data, 32'd0);
      req_valid = 2'b01;
      req_data0 = 32'h0000_00F1;
      req_amt0  = 5'd4;
      #2 reset_n = 1'b1;

      foreach (vecs[i]) begin
         req_valid  = vecs[i].valid;
         req_data0  = vecs[i].d0;
         req_amt0   = vecs[i].a0;
         req_data1  = vecs[i].d1;
         req_amt1   = vecs[i].a1;
         resp_ready = vecs[i].rr;
         #1;
         chk($sformatf("v%0d_req_ready", i), {30'd0, req_ready}, {30'd0, vecs[i].exp_ready});
         @(posedge clock);
         #1;
         chk($sformatf("v%0d_resp_valid", i), {31'd0, resp_valid}, {31'd0, vecs[i].exp_rv});
         if (vecs[i].chk_data) begin
            chk($sformatf("v%0d_resp_data", i), resp_data, vecs[i].exp_data);
            chk($sformatf("v%0d_resp_id", i), {31'd0, resp_id}, {31'd0, vecs[i].exp_id});
         end
         chk($sformatf("v%0d_done_count", i), {16'd0, done_count}, {16'd0, vecs[i].exp_cnt});
      end

      // Counter wrap: requester 0 alone, one handshake per cycle from the second edge on.
      req_valid  = 2'b01;
      req_data0  = 32'h1;
      req_amt0   = 5'd3;
      resp_ready = 1'b1;
      for (int k = 0; k < 65526; k++) @(posedge clock);
      #1;
      chk("wrap_pre_count", {16'd0, done_count}, 32'h0000_FFFF);
      @(posedge clock);
      #1;
      chk("wrap_count_zero", {16'd0, done_count}, 32'd0);
      chk("wrap_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("wrap_resp_data", resp_data, 32'h0000_0008);

      // Async reset while a result is held; pointer was last moved to requester 1.
      req_valid  = 2'b00;
      resp_ready = 1'b0;
      @(posedge clock);
      #1;
      chk("held_resp_valid", {31'd0, resp_valid}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("async_resp_data", resp_data, 32'd0);
      chk("async_done_count", {16'd0, done_count}, 32'd0);
      chk("async_req_ready", {30'd0, req_ready}, 32'd0);
      req_valid  = 2'b11;
      req_data0  = 32'h0000_0005;
      req_amt0   = 5'd1;
      req_data1  = 32'h0000_0007;
      req_amt1   = 5'd2;
      resp_ready = 1'b1;
      @(posedge clock);
      #1;
      chk("in_reset_resp_valid", {31'd0, resp_valid}, 32'd0);
      #2 reset_n = 1'b1;
      #1;
      chk("post_reset_ready", {30'd0, req_ready}, 32'd1);
      @(posedge clock);
      #1;
      chk("post_reset_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("post_reset_resp_id", {31'd0, resp_id}, 32'd0);
      chk("post_reset_resp_data", resp_data, 32'h0000_000A);
      chk("post_reset_ready_next", {30'd0, req_ready}, 32'd2);
      @(posedge clock);
      #1;
      chk("post_reset_resp_id_next", {31'd0, resp_id}, 32'd1);
      chk("post_reset_resp_data_next", resp_data, 32'h0000_001C);
      chk("post_reset_done_count", {16'd0, done_count}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
